pipelined_block_subtractor: RTL and testbench

- Pipelined unsigned/two's-complement subtractor: diff = a - b - bin, with borrow-out.
- Sliced into blocks of block_width bits; one block is resolved per pipeline stage using lookahead borrow within the block.
- Valid/ready handshake on both sides; throughput one operation per cycle; stalls propagate backward without loss.
- Serves as the datapath's subtract unit, the inverse of the block-carry adder.

---
 rtl/pipelined_block_subtractor_pkg.sv | 22 ++
 rtl/pipelined_block_subtractor_borrow_block.sv | 30 +++
 rtl/pipelined_block_subtractor.sv | 178 +++++++++++++++++
 tb/tb_pipelined_block_subtractor.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_block_subtractor_pkg.sv
// Shared definitions for the pipelined block subtractor: default geometry,
// stage-count helper and the per-stage record layout.
package pipelined_block_subtractor_pkg;

  localparam int unsigned SUB_WIDTH       = 32;
  localparam int unsigned SUB_BLOCK_WIDTH = 4;

  function automatic int unsigned num_stages(input int unsigned w, input int unsigned bw);
    return w / bw;
  endfunction

  // Logical content of one pipeline stage at the default geometry
  typedef struct packed {
    logic                 valid;
    logic [SUB_WIDTH-1:0] a_rem;
    logic [SUB_WIDTH-1:0] b_rem;
    logic [SUB_WIDTH-1:0] diff_done;
    logic                 borrow;
    logic [1:0]           flags;
  } stage_t;

endpackage

// File: rtl/pipelined_block_subtractor_borrow_block.sv
// One block_width slice of a - b - bin, built as a + ~b + ~bin with
// propagate/generate lookahead; borrow-out is the inverted carry-out.
module borrow_block #(
  parameter int unsigned block_width = 4
) (
  input  logic [block_width-1:0] a,
  input  logic [block_width-1:0] b,
  input  logic                   bin,
  output logic [block_width-1:0] diff,
  output logic                   bout
);

  logic [block_width-1:0] p;
  logic [block_width-1:0] g;
  logic [block_width:0]   c;

  always_comb begin
    p    = a ^ ~b;
    g    = a & ~b;
    c    = '0;
    c[0] = ~bin;
    for (int i = 0; i < int'(block_width); i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign diff = p ^ c[block_width-1:0];
  assign bout = ~c[block_width];

endmodule

// File: rtl/pipelined_block_subtractor.sv
// Pipelined subtractor resolving one block per stage with valid/ready flow control.
// Optional result flags (out_zero, out_ovf) are built when SUB_RESULT_FLAGS_EN is defined.
module pipelined_block_subtractor
  import pipelined_block_subtractor_pkg::*;
#(
  parameter int unsigned width       = SUB_WIDTH,
  parameter int unsigned block_width = SUB_BLOCK_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] diff,
  output logic             bout,
  output logic             out_zero,
  output logic             out_ovf
);

  localparam int unsigned N  = num_stages(width, block_width);
  localparam int unsigned BW = block_width;
  localparam int unsigned RW = width - block_width;

  if ((width % block_width) != 0) begin : g_bad_width
    $error("width must be a multiple of block_width");
  end
  if (N < 2) begin : g_bad_depth
    $error("block_width must be smaller than width");
  end

  logic [N-1:0] v_q;
  logic [N-1:0] free;
  logic [N-1:0] mv;
  logic [N-1:0] load;

  // Middle stages 0..N-2: remaining operand bits and completed diff bits
  logic [RW-1:0] a_q [N-1];
  logic [RW-1:0] b_q [N-1];
  logic [RW-1:0] d_q [N-1];
  logic [N-2:0]  br_q;

  logic [width-1:0] diff_q;
  logic             bout_q;

  logic [BW-1:0] a_blk [N];
  logic [BW-1:0] b_blk [N];
  logic [BW-1:0] blk_d [N];
  logic [N-1:0]  bin_blk;
  logic [N-1:0]  blk_b;

  // Advance chain: a stage frees up when empty or when its beat moves on
  always_comb begin
    mv   = '0;
    free = '0;
    load = '0;
    mv[N-1]   = v_q[N-1] & out_ready;
    free[N-1] = ~v_q[N-1] | mv[N-1];
    for (int k = int'(N) - 2; k >= 0; k--) begin
      mv[k]   = v_q[k] & free[k+1];
      free[k] = ~v_q[k] | mv[k];
    end
    load[0] = in_valid & free[0];
    for (int k = 1; k < int'(N); k++) begin
      load[k] = mv[k-1];
    end
  end

  assign in_ready = free[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        if (load[k])    v_q[k] <= 1'b1;
        else if (mv[k]) v_q[k] <= 1'b0;
      end
    end
  end

  always_comb begin
    a_blk[0]   = a[BW-1:0];
    b_blk[0]   = b[BW-1:0];
    bin_blk[0] = bin;
    for (int k = 1; k < int'(N); k++) begin
      a_blk[k]   = a_q[k-1][BW-1:0];
      b_blk[k]   = b_q[k-1][BW-1:0];
      bin_blk[k] = br_q[k-1];
    end
  end

  for (genvar k = 0; k < int'(N); k++) begin : g_stage
    borrow_block #(.block_width(BW)) u_blk (
      .a    (a_blk[k]),
      .b    (b_blk[k]),
      .bin  (bin_blk[k]),
      .diff (blk_d[k]),
      .bout (blk_b[k])
    );
  end

  // Finished blocks enter d_q from the top, so block 0 ends up lowest
  always_ff @(posedge clk) begin
    if (load[0]) begin
      a_q[0]  <= a[width-1:BW];
      b_q[0]  <= b[width-1:BW];
      d_q[0]  <= RW'({blk_d[0], RW'(0)} >> BW);
      br_q[0] <= blk_b[0];
    end
    for (int k = 1; k < int'(N) - 1; k++) begin
      if (load[k]) begin
        a_q[k]  <= a_q[k-1] >> BW;
        b_q[k]  <= b_q[k-1] >> BW;
        d_q[k]  <= RW'({blk_d[k], d_q[k-1]} >> BW);
        br_q[k] <= blk_b[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (load[N-1]) begin
      diff_q <= {blk_d[N-1], d_q[N-2]};
      bout_q <= blk_b[N-1];
    end
  end

  assign out_valid = v_q[N-1];
  assign diff      = diff_q;
  assign bout      = bout_q;

`ifdef SUB_RESULT_FLAGS_EN
  logic [N-2:0] z_q;
  logic [N-2:0] am_q;
  logic [N-2:0] bm_q;
  logic         zero_q;
  logic         ovf_q;

  // Sticky all-zero flag plus operand sign bits carried to the last stage
  always_ff @(posedge clk) begin
    if (load[0]) begin
      z_q[0]  <= (blk_d[0] == '0);
      am_q[0] <= a[width-1];
      bm_q[0] <= b[width-1];
    end
    for (int k = 1; k < int'(N) - 1; k++) begin
      if (load[k]) begin
        z_q[k]  <= z_q[k-1] & (blk_d[k] == '0);
        am_q[k] <= am_q[k-1];
        bm_q[k] <= bm_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (load[N-1]) begin
      zero_q <= z_q[N-2] & (blk_d[N-1] == '0);
      ovf_q  <= (am_q[N-2] != bm_q[N-2]) && (blk_d[N-1][BW-1] != am_q[N-2]);
    end
  end

  assign out_zero = zero_q;
  assign out_ovf  = ovf_q;
`else
  assign out_zero = 1'b0;
  assign out_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_block_subtractor.sv
// Scoreboard bench for pipelined_block_subtractor (default 32-bit, 4-bit blocks).
// Honours SUB_RESULT_FLAGS_EN when computing expected flags.
module tb_pipelined_block_subtractor;

  localparam int unsigned W = 32;
  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         out_zero;
  logic         out_ovf;

  always #5 clk = ~clk;

  pipelined_block_subtractor dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    logic         o;
  } res_t;

  res_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  logic rdone;

  // Reference: wide unsigned subtraction, borrow is the extra top bit
  function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    res_t       r;
    logic [W:0] f;
    f    = {1'b0, av} - {1'b0, bv} - (W+1)'(bi);
    r.d  = f[W-1:0];
    r.bo = f[W];
`ifdef SUB_RESULT_FLAGS_EN
    r.z  = (r.d == '0);
    r.o  = (av[W-1] != bv[W-1]) && (r.d[W-1] != av[W-1]);
`else
    r.z  = 1'b0;
    r.o  = 1'b0;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer, checks stability while stalled
  res_t held_v;
  logic held = 1'b0;
  always @(negedge clk) begin
    res_t cur;
    res_t e;
    cur = {diff, bout, out_zero, out_ovf};
    if (rst) begin
      held = 1'b0;
    end else if (out_valid) begin
      if (held) check("stall_stable", 64'(cur), 64'(held_v));
      if (out_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %h expected none (t=%0t)", cur, $time);
        end else begin
          e = sbq.pop_front();
          check("result", 64'(cur), 64'(e));
        end
        held = 1'b0;
      end else begin
        held   = 1'b1;
        held_v = cur;
      end
    end else if (held) begin
      total++;
      bad++;
      $display("FAIL valid_dropped: got out_valid 0 expected 1 (t=%0t)", $time);
      held = 1'b0;
    end
  end

  // Starts and ends at posedge+1
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi, output int waits);
    logic ok;
    ok = 1'b0;
    waits = 0;
    a = av;
    b = bv;
    bin = bi;
    in_valid = 1'b1;
    while (!ok && waits < 100) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      waits++;
    end
    if (ok) begin
      sbq.push_back(model(av, bv, bi));
    end else begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept expected accept (t=%0t)", $time);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    check(name, 64'(sbq.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    int w;
    int lat;
    send(av, bv, bi, w);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(N - 1));
    wait_drain("directed_drain");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  w;
    int  acc;
    logic ok;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    out_ready = 1'b1;
    rdone = 1'b0;

    #12;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_diff", 64'(diff), 64'(0));
    check("reset_flags", 64'({bout, out_zero, out_ovf}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    directed(32'd5, 32'd3, 1'b0);
    directed(32'd0, 32'd1, 1'b0);
    directed(32'h1234, 32'h1233, 1'b1);
    directed(32'h8000_0000, 32'd1, 1'b0);
    directed(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);

    // Back-to-back stream
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          send(32'(i) * 32'h1111_1111, 32'(i), 1'b0, w);
          check("tp_in_ready", 64'(w), 64'(1));
        end
      end
      begin
        int t;
        int run;
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!out_valid && t < 50);
        run = 0;
        while (out_valid && run < 40) begin
          run++;
          @(negedge clk);
        end
        check("tp_consecutive", 64'(run), 64'(20));
      end
    join
    wait_drain("tp_drain");

    // Backpressure: fill the pipe with the consumer stalled
    out_ready = 1'b0;
    acc = 0;
    a = $urandom;
    b = $urandom;
    bin = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      if (ok) begin
        sbq.push_back(model(a, b, bin));
        acc++;
      end
      #1;
      if (ok) begin
        a = $urandom;
        b = $urandom;
        bin = 1'($urandom_range(0, 1));
      end
    end
    in_valid = 1'b0;
    check("bp_accepted", 64'(acc), 64'(N));
    @(negedge clk);
    check("bp_full_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("bp_drain");

    // Random traffic with random consumer stalls
    fork
      begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          ra = $urandom;
          rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
          send(ra, rb, 1'($urandom_range(0, 1)), w);
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain("rand_drain");

    // Reset with beats in flight
    for (int i = 0; i < 5; i++) send($urandom, $urandom, 1'b0, w);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_diff", 64'(diff), 64'(0));
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_no_stale", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    directed(32'd9, 32'd4, 1'b0);
    repeat (20) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
